simon_core: RTL

Parametrised Simon game engine and successor to the fixed 4-button, 2-bit-LFSR game. It integrates sequence generation, sequence storage, playback timing, input checking, input timeout and a win condition in one block. The block runs on the system clock and advances its timers on a single-cycle `tick` enable from an upstream tick generator, so it needs no divided clock. Button debouncing happens upstream; the LED and 7-segment drivers downstream consume `led`, `level` and `state`.

---
 rtl/simon_pkg.sv | 39 +++
 rtl/simon_lfsr.sv | 27 ++
 rtl/simon_core.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simon_pkg
// Brief    : Shared state codes, LFSR feedback mask and one-hot helpers for
//            the Simon game engine.
// Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WAIT_REL = 3'd5,
        S_FAIL     = 3'd6,
        S_WIN      = 3'd7
    } simon_state_e;

    localparam logic [15:0] c_LFSR_MASK = 16'hB400;
    localparam int          c_MAX_CH    = 16;

    // Helpers take the widest channel vector; narrower vectors are zero-extended.
    function automatic logic f_is_onehot(input logic [c_MAX_CH-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    function automatic logic [3:0] f_onehot_idx(input logic [c_MAX_CH-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_CH; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage : simon_pkg
`default_nettype wire

// File: rtl/simon_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : simon_lfsr
// Brief    : Free-running 16-bit Galois LFSR used as the colour source.
// Revision : 1.0 - initial release
// ============================================================================
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lfsr <= SEED;
        else          r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
    end

    assign o_lfsr = r_lfsr;

endmodule : simon_lfsr
`default_nettype wire

// File: rtl/simon_core.sv
`default_nettype none
// ============================================================================
// Module   : simon_core
// Brief    : Parametrised Simon game engine: sequence generation, playback,
//            input checking, timeout and win detection on a tick enable.
// Revision : 1.0 - initial release
// ============================================================================
module simon_core
    import simon_pkg::*;
#(
    parameter int          NUM_CH        = 4,
    parameter int          MAX_LEN       = 16,
    parameter int          ON_TICKS      = 2,
    parameter int          OFF_TICKS     = 1,
    parameter int          TIMEOUT_TICKS = 20,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             tick,
    input  logic                             start,
    input  logic [NUM_CH-1:0]                btn,
    output logic [NUM_CH-1:0]                led,
    output logic                             error_led,
    output logic                             win_led,
    output logic [$clog2(MAX_LEN+1)-1:0]     level,
    output logic [2:0]                       state
);

    localparam int c_CH_W    = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);
    localparam int c_LEN_W   = $clog2(MAX_LEN + 1);
    localparam int c_ADDR_W  = (MAX_LEN <= 2) ? 1 : $clog2(MAX_LEN);
    localparam int c_TMR_MAX = (ON_TICKS > OFF_TICKS)
                             ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                             : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    simon_state_e        r_state, w_state_nxt;
    logic [c_LEN_W-1:0]  r_level, w_level_nxt;
    logic [c_LEN_W-1:0]  r_index, w_index_nxt;
    logic [c_TMR_W-1:0]  r_timer;
    logic [NUM_CH-1:0]   r_btn_prev;
    logic [c_CH_W-1:0]   r_mem [MAX_LEN];

    logic [15:0]         w_lfsr;
    logic [c_CH_W-1:0]   w_raw, w_colour, w_cur;
    logic                w_press, w_match, w_last;
    logic                w_on_done, w_off_done, w_timeout;
    logic                w_unused_lfsr;

    simon_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .o_lfsr  (w_lfsr)
    );

    // Only the low bits pick a colour; a single fold maps them into range.
    assign w_raw         = w_lfsr[c_CH_W-1:0];
    assign w_colour      = ({1'b0, w_raw} >= (c_CH_W+1)'(NUM_CH)) ? w_raw - c_CH_W'(NUM_CH) : w_raw;
    assign w_unused_lfsr = ^w_lfsr;

    assign w_cur      = r_mem[r_index[c_ADDR_W-1:0]];
    assign w_last     = (r_index == r_level - c_LEN_W'(1));
    assign w_press    = f_is_onehot(16'(btn)) && (r_btn_prev == '0);
    assign w_match    = (f_onehot_idx(16'(btn)) == 4'(w_cur));
    assign w_on_done  = tick && (r_timer == c_TMR_W'(ON_TICKS - 1));
    assign w_off_done = tick && (r_timer == c_TMR_W'(OFF_TICKS - 1));
    assign w_timeout  = (TIMEOUT_TICKS != 0) && tick && (r_timer == c_TMR_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_level    <= '0;
            r_index    <= '0;
            r_timer    <= '0;
            r_btn_prev <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_index    <= w_index_nxt;
            r_btn_prev <= btn;
            if (start || (w_state_nxt != r_state)) r_timer <= '0;
            else if (tick)                         r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_ADD) && !start) r_mem[r_level[c_ADDR_W-1:0]] <= w_colour;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_index_nxt = r_index;
        if (start) begin
            w_state_nxt = S_ADD;
            w_level_nxt = '0;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                S_ADD: begin
                    w_level_nxt = r_level + c_LEN_W'(1);
                    w_index_nxt = '0;
                    w_state_nxt = S_SHOW_ON;
                end
                S_SHOW_ON: if (w_on_done) w_state_nxt = S_SHOW_OFF;
                S_SHOW_OFF: begin
                    if (w_off_done) begin
                        w_index_nxt = w_last ? '0 : r_index + c_LEN_W'(1);
                        w_state_nxt = w_last ? S_WAIT_IN : S_SHOW_ON;
                    end
                end
                // A press in the same cycle as the final tick takes precedence.
                S_WAIT_IN: begin
                    if (w_press)        w_state_nxt = w_match ? S_WAIT_REL : S_FAIL;
                    else if (w_timeout) w_state_nxt = S_FAIL;
                end
                S_WAIT_REL: begin
                    if (btn == '0) begin
                        if (!w_last) begin
                            w_index_nxt = r_index + c_LEN_W'(1);
                            w_state_nxt = S_WAIT_IN;
                        end else if (r_level == c_LEN_W'(MAX_LEN)) begin
                            w_state_nxt = S_WIN;
                        end else begin
                            w_state_nxt = S_ADD;
                        end
                    end
                end
                S_IDLE, S_FAIL, S_WIN: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        led = '0;
        case (r_state)
            S_SHOW_ON:  led = NUM_CH'(1) << w_cur;
            S_WAIT_REL: led = r_btn_prev;
            S_WIN:      led = '1;
            default:    led = '0;
        endcase
    end

    assign error_led = (r_state == S_FAIL);
    assign win_led   = (r_state == S_WIN);
    assign level     = r_level;
    assign state     = r_state;

endmodule : simon_core
`default_nettype wire
